// File: rtl/sprite_blit_engine.sv
// Sprite rasteriser: on an accepted start it walks one SPR_W x SPR_H sprite at a latched
// anchor, one registered pixel per clock, with mirrored drawing and screen-edge clipping.
module sprite_blit_engine #(
  parameter int unsigned SPR_W    = 5,
  parameter int unsigned SPR_H    = 5,
  parameter int unsigned COORD_W  = 8,
  parameter int unsigned COLOR_W  = 3,
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120,
  parameter logic [SPR_W*SPR_H-1:0] BODY_MAP  = 25'h0E27C80,
  parameter logic [SPR_W*SPR_H-1:0] FLAME_MAP = 25'h0000004,
  parameter logic [COLOR_W-1:0] BODY_COLOR  = 3'b111,
  parameter logic [COLOR_W-1:0] FLAME_COLOR = 3'b100,
  parameter logic [COLOR_W-1:0] BG_COLOR    = 3'b000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [COORD_W-1:0] x_in,
  input  logic [COORD_W-1:0] y_in,
  output logic               busy,
  output logic               done,
  output logic               plot,
  output logic [COORD_W-1:0] x_out,
  output logic [COORD_W-1:0] y_out,
  output logic [COLOR_W-1:0] color_out
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t             state;
  logic [1:0]         op_q;
  logic [COORD_W-1:0] anchor_x;
  logic [COORD_W-1:0] anchor_y;
  logic [3:0]         row;
  logic [3:0]         col;

  logic [3:0]             bc;
  logic [7:0]             idx;
  logic [SPR_W*SPR_H-1:0] body_sh;
  logic [SPR_W*SPR_H-1:0] flame_sh;
  logic [COORD_W:0]       sum_x;
  logic [COORD_W:0]       sum_y;
  logic                   in_bounds;
  logic                   last_pix;
  logic [COLOR_W-1:0]     pix_color;

  always_comb begin
    bc        = (op_q == 2'd3) ? (4'(SPR_W - 1) - col) : col;
    idx       = 8'(row) * 8'(SPR_W) + 8'(bc);
    // Shifting avoids an index wider than the bitmap's natural index width.
    body_sh   = BODY_MAP >> idx;
    flame_sh  = FLAME_MAP >> idx;
    sum_x     = {1'b0, anchor_x} + (COORD_W+1)'(col);
    sum_y     = {1'b0, anchor_y} + (COORD_W+1)'(row);
    in_bounds = (sum_x < (COORD_W+1)'(SCREEN_W)) && (sum_y < (COORD_W+1)'(SCREEN_H));
    last_pix  = (row == 4'(SPR_H - 1)) && (col == 4'(SPR_W - 1));
    pix_color = BG_COLOR;
    case (op_q)
      2'd1:    pix_color = BG_COLOR;
      2'd2:    pix_color = flame_sh[0] ? FLAME_COLOR : (body_sh[0] ? BODY_COLOR : BG_COLOR);
      default: pix_color = body_sh[0] ? BODY_COLOR : BG_COLOR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      op_q      <= '0;
      anchor_x  <= '0;
      anchor_y  <= '0;
      row       <= '0;
      col       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      plot      <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      color_out <= '0;
    end else begin
      // Status outputs trail the state by one cycle so every output stays registered.
      busy <= (state != IDLE);
      done <= 1'b0;
      plot <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q     <= op;
            anchor_x <= x_in;
            anchor_y <= y_in;
            row      <= '0;
            col      <= '0;
            state    <= SCAN;
          end
        end
        SCAN: begin
          plot      <= in_bounds;
          x_out     <= sum_x[COORD_W-1:0];
          y_out     <= sum_y[COORD_W-1:0];
          color_out <= pix_color;
          if (last_pix) begin
            state <= DONE;
          end else if (col == 4'(SPR_W - 1)) begin
            col <= '0;
            row <= row + 4'd1;
          end else begin
            col <= col + 4'd1;
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_blit_engine.sv
// Randomised scoreboard bench for sprite_blit_engine: a default-map instance and an
// asymmetric-map instance are driven together and checked against a pixel-list model.
module tb_sprite_blit_engine;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] c;
  } pix_t;

  localparam logic [24:0] MAP_A_BODY  = 25'h0E27C80;
  localparam logic [24:0] MAP_A_FLAME = 25'h0000004;
  localparam logic [24:0] MAP_B_BODY  = 25'h1A35C21;
  localparam logic [24:0] MAP_B_FLAME = 25'h0000010;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] op_i = '0;
  logic [7:0] x_i = '0;
  logic [7:0] y_i = '0;

  logic       busy_a, done_a, plot_a, busy_b, done_b, plot_b;
  logic [7:0] x_a, y_a, x_b, y_b;
  logic [2:0] c_a, c_b;

  int   checks = 0;
  int   errors = 0;
  pix_t qa[$];
  pix_t qb[$];

  always #5 clk = ~clk;

  sprite_blit_engine dut_a (
    .clk(clk), .reset(reset), .start(start), .op(op_i), .x_in(x_i), .y_in(y_i),
    .busy(busy_a), .done(done_a), .plot(plot_a), .x_out(x_a), .y_out(y_a), .color_out(c_a)
  );

  sprite_blit_engine #(
    .BODY_MAP(MAP_B_BODY),
    .FLAME_MAP(MAP_B_FLAME)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start), .op(op_i), .x_in(x_i), .y_in(y_i),
    .busy(busy_b), .done(done_b), .plot(plot_b), .x_out(x_b), .y_out(y_b), .color_out(c_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: list of every on-screen pixel in raster order with its colour.
  task automatic model(input bit to_b, input logic [1:0] o, input logic [7:0] ax,
                       input logic [7:0] ay);
    logic [24:0] bm, fm;
    pix_t p;
    int sx, sy, bcol, bit_i;
    bm = to_b ? MAP_B_BODY : MAP_A_BODY;
    fm = to_b ? MAP_B_FLAME : MAP_A_FLAME;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        bcol  = (o == 2'd3) ? 4 - c : c;
        bit_i = r * 5 + bcol;
        sx = int'(ax) + c;
        sy = int'(ay) + r;
        if (sx < 160 && sy < 120) begin
          p.x = sx[7:0];
          p.y = sy[7:0];
          if (o == 2'd1)                    p.c = 3'b000;
          else if (o == 2'd2 && fm[bit_i])  p.c = 3'b100;
          else if (bm[bit_i])               p.c = 3'b111;
          else                              p.c = 3'b000;
          if (to_b) qb.push_back(p);
          else      qa.push_back(p);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (plot_a === 1'b1) begin
      if (qa.size() == 0) chk("unexpected_plot_a", {13'd0, x_a, y_a, c_a}, 32'hFFFF_FFFF);
      else                chk("pixel_a", {13'd0, x_a, y_a, c_a}, {13'd0, qa.pop_front()});
    end
    if (plot_b === 1'b1) begin
      if (qb.size() == 0) chk("unexpected_plot_b", {13'd0, x_b, y_b, c_b}, 32'hFFFF_FFFF);
      else                chk("pixel_b", {13'd0, x_b, y_b, c_b}, {13'd0, qb.pop_front()});
    end
  end

  // mode: 0 plain, 1 stray start mid-scan, 2 reset abort at N+10, 3 start held (two blits)
  task automatic run(input logic [1:0] o, input logic [7:0] ax, input logic [7:0] ay,
                     input int mode);
    int  kmax;
    bit  eb, ed;
    kmax = (mode == 3) ? 55 : 28;
    @(negedge clk);
    model(1'b0, o, ax, ay);
    model(1'b1, o, ax, ay);
    if (mode == 3) begin
      model(1'b0, o, ax, ay);
      model(1'b1, o, ax, ay);
    end
    op_i  = o;
    x_i   = ax;
    y_i   = ay;
    start = 1'b1;
    for (int k = 0; k <= kmax; k++) begin
      @(negedge clk);
      if (mode != 3 && k == 0) begin
        start = 1'b0;
        op_i  = 2'($urandom);
        x_i   = 8'($urandom);
        y_i   = 8'($urandom);
      end
      if (mode == 3 && k == 27) start = 1'b0;
      if (mode == 1 && k == 4) begin
        start = 1'b1;
        op_i  = 2'd1;
        x_i   = 8'd3;
      end
      if (mode == 1 && k == 5) start = 1'b0;
      if (mode == 2 && k == 9) reset = 1'b1;
      if (mode == 2 && k == 10) begin
        reset = 1'b0;
        chk("abort_plot_a", {31'd0, plot_a}, 32'd0);
        chk("abort_plot_b", {31'd0, plot_b}, 32'd0);
        qa.delete();
        qb.delete();
      end
      eb = (k >= 1 && k <= 26) || (mode == 3 && k >= 28 && k <= 53);
      ed = (k == 26) || (mode == 3 && k == 53);
      if (mode == 2 && k >= 10) begin
        eb = 1'b0;
        ed = 1'b0;
      end
      chk($sformatf("busy_a k=%0d", k), {31'd0, busy_a}, {31'd0, eb});
      chk($sformatf("done_a k=%0d", k), {31'd0, done_a}, {31'd0, ed});
      chk($sformatf("busy_b k=%0d", k), {31'd0, busy_b}, {31'd0, eb});
      chk($sformatf("done_b k=%0d", k), {31'd0, done_b}, {31'd0, ed});
    end
    chk("leftover_a", qa.size(), 32'd0);
    chk("leftover_b", qb.size(), 32'd0);
    qa.delete();
    qb.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_done", {31'd0, done_a}, 32'd0);
    chk("rst_plot", {31'd0, plot_a}, 32'd0);
    chk("rst_xyc_a", {13'd0, x_a, y_a, c_a}, 32'd0);
    chk("rst_xyc_b", {13'd0, x_b, y_b, c_b}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", {31'd0, busy_a | busy_b}, 32'd0);

    run(2'd0, 8'd82,  8'd110, 0);
    run(2'd2, 8'd82,  8'd110, 0);
    run(2'd0, 8'd158, 8'd50,  0);
    run(2'd3, 8'd0,   8'd0,   0);
    run(2'd0, 8'd0,   8'd0,   0);
    run(2'd3, 8'd40,  8'd117, 0);
    run(2'd0, 8'd82,  8'd110, 1);
    run(2'd0, 8'd82,  8'd110, 2);
    run(2'd1, 8'd10,  8'd10,  3);
    run(2'd2, 8'd255, 8'd254, 0);
    for (int i = 0; i < 24; i++) begin
      logic [1:0] ro;
      logic [7:0] rx, ry;
      ro = 2'($urandom);
      rx = ($urandom % 2 == 0) ? 8'($urandom_range(150, 165)) : 8'($urandom);
      ry = ($urandom % 2 == 0) ? 8'($urandom_range(110, 125)) : 8'($urandom_range(0, 119));
      run(ro, rx, ry, (i % 6 == 5) ? 3 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
